// File: rtl/binary_to_decimal_converter_if.sv
// Handshake and digit bus between a binary source, the BCD converter and the display.
// The master drives the operand and start; the slave returns status and the four digits.
interface binary_to_decimal_converter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] value;
    logic             start;
    logic             busy;
    logic             done;
    logic [3:0]       digit_1;
    logic [3:0]       digit_2;
    logic [3:0]       digit_3;
    logic [3:0]       digit_4;

    modport master (
        output value, start,
        input  busy, done, digit_1, digit_2, digit_3, digit_4
    );

    modport slave (
        input  value, start,
        output busy, done, digit_1, digit_2, digit_3, digit_4
    );
endinterface

// File: rtl/binary_to_decimal_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Digits are only replaced on the completion edge, so the display never sees partial results.
module binary_to_decimal_converter #(
    parameter int unsigned WIDTH = 8,
    parameter bit          AUTO  = 1'b0
) (
    input logic                          clock,
    input logic                          reset,
    binary_to_decimal_converter_if.slave bus
);
    localparam int unsigned W = 16 + WIDTH;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_n;
    logic [W-1:0]     work_q, work_n;
    logic [W-1:0]     adjusted;
    logic [W-1:0]     shifted;
    logic [3:0]       count_q, count_n;
    logic [WIDTH-1:0] last_q, last_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic [15:0]      digits_q, digits_n;
    logic             trigger;

    // Each BCD nibble is corrected on its own; no carry crosses nibble boundaries.
    always_comb begin
        adjusted = work_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (work_q[WIDTH + 4*i +: 4] >= 4'd5)
                adjusted[WIDTH + 4*i +: 4] = work_q[WIDTH + 4*i +: 4] + 4'd3;
        end
    end

    assign shifted = {adjusted[W-2:0], 1'b0};
    assign trigger = AUTO ? (bus.value != last_q) : bus.start;

    always_comb begin
        state_n  = state_q;
        work_n   = work_q;
        count_n  = count_q;
        last_n   = last_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        digits_n = digits_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    work_n  = {16'b0, bus.value};
                    last_n  = bus.value;
                    count_n = 4'(WIDTH);
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                work_n  = shifted;
                count_n = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    digits_n = shifted[W-1:WIDTH];
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            count_q  <= '0;
            last_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
        end else begin
            state_q  <= state_n;
            work_q   <= work_n;
            count_q  <= count_n;
            last_q   <= last_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            digits_q <= digits_n;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.digit_1 = digits_q[15:12];
    assign bus.digit_2 = digits_q[11:8];
    assign bus.digit_3 = digits_q[7:4];
    assign bus.digit_4 = digits_q[3:0];
endmodule
